// File: rtl/pc_unit.sv
// pc_unit: MIPS fetch-stage program counter with prioritised redirects, stall latch and optional RAS
// Optional feature macro: PC_RAS_EN (compiles in a RAS_DEPTH-entry return-address stack)
// Ports: clock, reset (sync, active-high); stall, exception, branch_taken/branch_target,
//   jump/jump_target, call, ret in; pc, pc_plus_inc, redirect_pending, ras_empty out
module pc_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h8000_0180),
  parameter int INC = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              exception,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_inc,
  output logic              redirect_pending,
  output logic              ras_empty
);
  logic              pend_valid, pend_branch, pend_call, pend_ret;
  logic [ADDR_W-1:0] pend_target, eff_target, ras_top, next_pc;
  logic              act, cap, eff_jump, j_call, j_ret, pop_hit;
  assign pc_plus_inc = pc + ADDR_W'(INC);
  assign redirect_pending = pend_valid;
  // a new request may replace the latched one only at equal or higher priority (branch >= jump)
  assign cap = stall & (branch_taken | (jump & (~pend_valid | ~pend_branch)));
  // on the release cycle the latched redirect wins over anything new
  assign act = ~stall & ~exception;
  assign eff_jump = pend_valid ? ~pend_branch : ~branch_taken & jump;
  assign eff_target = pend_valid ? pend_target : branch_taken ? branch_target : jump_target;
  assign j_call = act & eff_jump & (pend_valid ? pend_call : call);
  assign j_ret = act & eff_jump & (pend_valid ? pend_ret : ret);
  assign next_pc = exception ? EXC_VECTOR :
                   stall ? pc :
                   pop_hit ? ras_top :
                   (pend_valid | branch_taken | jump) ? eff_target : pc_plus_inc;
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_VECTOR;
      pend_valid <= 1'b0;
      pend_branch <= 1'b0;
      pend_call <= 1'b0;
      pend_ret <= 1'b0;
      pend_target <= '0;
    end else begin
      pc <= next_pc;
      if (exception || (!stall && pend_valid)) pend_valid <= 1'b0;
      else if (cap) begin
        pend_valid <= 1'b1;
        pend_branch <= branch_taken;
        pend_target <= branch_taken ? branch_target : jump_target;
        pend_call <= ~branch_taken & call;
        pend_ret <= ~branch_taken & ret;
      end
    end
  end
`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]     top, top_up, top_dn;
  logic [CW-1:0]     cnt;
  assign ras_empty = cnt == '0;
  assign top_up = top == PW'(RAS_DEPTH - 1) ? '0 : top + 1'b1;
  assign top_dn = top == '0 ? PW'(RAS_DEPTH - 1) : top - 1'b1;
  assign ras_top = ras[top];
  // call+ret replaces the top entry, so no pop happens in that case
  assign pop_hit = j_ret & ~j_call & ~ras_empty;
  always_ff @(posedge clock) begin
    if (reset) begin
      top <= '0;
      cnt <= '0;
    end else if (j_call && j_ret) ras[top] <= pc_plus_inc;
    else if (j_call) begin
      ras[top_up] <= pc_plus_inc;
      top <= top_up;
      if (cnt != CW'(RAS_DEPTH)) cnt <= cnt + 1'b1;
    end else if (pop_hit) begin
      top <= top_dn;
      cnt <= cnt - 1'b1;
    end
  end
`else
  logic unused_ras;
  assign ras_empty = 1'b1;
  assign ras_top = '0;
  assign pop_hit = 1'b0;
  assign unused_ras = ^{j_call, j_ret, RAS_DEPTH > 1};
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit
module tb_pc_unit;
  logic        clock = 1'b0, reset, stall, exception, branch_taken, jump, call, ret;
  logic [31:0] branch_target, jump_target, pc, pc_plus_inc, pc_rv, ppi_rv;
  logic        redirect_pending, ras_empty, rp_rv, re_rv;
  int          checks = 0, failures = 0;
  always #5 clock = ~clock;
  pc_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .exception(exception),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .call(call), .ret(ret),
    .pc(pc), .pc_plus_inc(pc_plus_inc), .redirect_pending(redirect_pending), .ras_empty(ras_empty)
  );
  pc_unit #(.RESET_VECTOR(32'h400)) dut_rv (
    .clock(clock), .reset(reset), .stall(stall), .exception(exception),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .call(call), .ret(ret),
    .pc(pc_rv), .pc_plus_inc(ppi_rv), .redirect_pending(rp_rv), .ras_empty(re_rv)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic idle;
    stall = 0; exception = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
  endtask
  initial begin
    idle();
    reset = 1; branch_target = 0; jump_target = 0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ppi", pc_plus_inc, 32'h4);
    chk("rst_pend", {31'b0, redirect_pending}, 32'h0);
    chk("rst_empty", {31'b0, ras_empty}, 32'h1);
    chk("rst_vec", pc_rv, 32'h400);
    reset = 0;
    step(); chk("run_4", pc, 32'h4);
    step(); chk("run_8", pc, 32'h8);
    step(); chk("run_c", pc, 32'hC);
    chk("run_rv", pc_rv, 32'h40C);
    branch_taken = 1; branch_target = 32'h100; jump = 1; jump_target = 32'h200;
    step(); chk("prio_br", pc, 32'h100);
    exception = 1;
    step(); chk("prio_exc", pc, 32'h8000_0180);
    idle(); jump = 1; jump_target = 32'h20;
    step(); chk("jmp_20", pc, 32'h20);
    idle(); stall = 1; jump = 1; jump_target = 32'h300;
    step(); chk("st1_pc", pc, 32'h20); chk("st1_pend", {31'b0, redirect_pending}, 32'h1);
    jump = 0; branch_taken = 1; branch_target = 32'h500;
    step(); chk("st2_pc", pc, 32'h20);
    branch_taken = 0;
    step(); chk("st3_pc", pc, 32'h20); chk("st3_pend", {31'b0, redirect_pending}, 32'h1);
    stall = 0;
    step(); chk("rel_pc", pc, 32'h500); chk("rel_pend", {31'b0, redirect_pending}, 32'h0);
    step(); chk("rel_next", pc, 32'h504);
    stall = 1; branch_taken = 1; branch_target = 32'h600;
    step();
    branch_taken = 0; jump = 1; jump_target = 32'h700;
    step(); chk("lo_prio_hold", pc, 32'h504);
    stall = 0; jump_target = 32'h900;
    step(); chk("latch_wins", pc, 32'h600);
    jump = 0;
    step(); chk("latch_next", pc, 32'h604);
    stall = 1; branch_taken = 1; branch_target = 32'h800;
    step(); chk("exs_pend", {31'b0, redirect_pending}, 32'h1);
    branch_taken = 0; exception = 1;
    step(); chk("exs_pc", pc, 32'h8000_0180); chk("exs_clr", {31'b0, redirect_pending}, 32'h0);
    idle();
    step(); chk("exs_after", pc, 32'h8000_0184);
    jump = 1; jump_target = 32'hFFFF_FFFC;
    step(); chk("wrap_pc", pc, 32'hFFFF_FFFC); chk("wrap_ppi", pc_plus_inc, 32'h0);
    jump = 0;
    step(); chk("wrap_next", pc, 32'h0);
    stall = 1; branch_taken = 1; branch_target = 32'hA00;
    step(); chk("rms_pend", {31'b0, redirect_pending}, 32'h1);
    branch_taken = 0; reset = 1;
    step(); chk("rms_pc", pc, 32'h0); chk("rms_clr", {31'b0, redirect_pending}, 32'h0);
    chk("rms_rv", pc_rv, 32'h400);
    reset = 0; stall = 0;
    step(); chk("rms_after", pc, 32'h4);
    jump = 1; jump_target = 32'h10;
    step(); chk("ras_start", pc, 32'h10);
`ifdef PC_RAS_EN
    call = 1; jump_target = 32'h40;
    step(); chk("call1", pc, 32'h40); chk("call1_ne", {31'b0, ras_empty}, 32'h0);
    jump_target = 32'h80; step();
    jump_target = 32'hC0; step();
    jump_target = 32'h100; step();
    jump_target = 32'h200; step(); chk("call5", pc, 32'h200);
    call = 0; ret = 1; jump_target = 32'hDEAD;
    step(); chk("ret1", pc, 32'h104);
    step(); chk("ret2", pc, 32'hC4);
    step(); chk("ret3", pc, 32'h84);
    step(); chk("ret4", pc, 32'h44);
    step(); chk("ret5", pc, 32'hDEAD); chk("ret_empty", {31'b0, ras_empty}, 32'h1);
`else
    call = 1; ret = 1; jump_target = 32'h123;
    step(); chk("noras_jr", pc, 32'h123); chk("noras_empty", {31'b0, ras_empty}, 32'h1);
`endif
    idle();
    step(); chk("final_inc", pc, pc_rv + 32'h0 == 32'h0 ? 32'h0 : pc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS fetch stage. It is the next generation of the single-register PC and replaces the two-way branch/increment mux with the following:
- an internal incrementer;
- a prioritised redirect selector (exception, branch, jump, return);
- stall handling, with a one-entry pending-redirect latch;
- an optional return-address stack (RAS).

It drives the instruction-memory address and feeds pc_plus_inc to the IF/ID pipeline register.

## Interface

Parameters:
- ADDR_W, 32: PC width in bits.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180: exception handler address.
- INC, 4: sequential increment, in bytes.
- RAS_DEPTH, 4: number of RAS entries, ≥2. Used only with PC_RAS_EN.

Ports:
- clock, in, 1: single clock; all state updates on posedge.
- reset, in, 1: synchronous, active-high reset.
- stall, in, 1: hold PC (hazard or memory wait).
- exception, in, 1: redirect to EXC_VECTOR.
- branch_taken, in, 1: take branch_target.
- branch_target, in, ADDR_W: branch destination.
- jump, in, 1: take jump_target (j, jal, jr).
- jump_target, in, ADDR_W: jump destination.
- call, in, 1: current redirect is a jal; push the return address (RAS only).
- ret, in, 1: current jump is a jr $ra; pop the RAS (RAS only).
- pc, out, ADDR_W: registered address to instruction memory.
- pc_plus_inc, out, ADDR_W: combinational pc + INC.
- redirect_pending, out, 1: the pending latch holds a redirect.
- ras_empty, out, 1: RAS holds no entries. Tied to 1 without PC_RAS_EN.

## Operation

- Next-PC priority, highest first:
  1. exception
  2. pending latch (if valid)
  3. branch_taken
  4. jump (ret variant when RAS is enabled)
  5. pc_plus_inc
- Arithmetic: pc_plus_inc = (pc + INC) mod 2^ADDR_W. At 0xFFFF_FFFC with INC=4 it wraps to 0x0000_0000 and no flag is raised.
- Stall:
  - pc holds its value.
  - A branch_taken or jump arriving while stalled is captured in the pending latch, and redirect_pending is set.
  - A later redirect during the same stall overwrites the latch only if its priority is ≥ that of the latched one (branch ≥ jump).
- Stall release: on the first non-stalled cycle, pc loads the latched target and the latch clears. If a new redirect also arrives that cycle, the latched target wins and the new request is dropped; upstream must not issue it.
- Exception: overrides stall and loads EXC_VECTOR on the next edge. It also clears the pending latch. With RAS enabled, the RAS keeps its contents.
- RAS (PC_RAS_EN only):
  - Circular buffer with a top pointer and an occupancy count of 0..RAS_DEPTH.
  - call with a non-stalled jump: push pc_plus_inc. When full, the oldest entry is overwritten and the count saturates.
  - ret with jump, not empty: next PC = RAS top, pop, and jump_target is ignored.
  - ret with jump, empty: next PC = jump_target; the count stays 0.
  - call and ret together: the top entry is replaced with pc_plus_inc and the count is unchanged.
  - call/ret during stall: deferred with the pending latch; the push or pop executes on release.
  - call/ret without jump: ignored.

## Timing

- Latency: one cycle. A request sampled at edge N appears on pc after edge N.
- Reset:
  - pc = RESET_VECTOR
  - redirect_pending = 0
  - RAS count = 0, so ras_empty = 1
  - pending latch cleared
- Reset dominates exception, stall and all redirects.
- Reset asserted mid-stall with a pending redirect discards the redirect.
- pc_plus_inc follows pc combinationally in the same cycle.
- redirect_pending asserts on the edge after the capturing cycle and clears on the release edge.

## Configuration

- PC_RAS_EN defined:
  - RAS_DEPTH-entry return-address stack compiled in.
  - call/ret active as described in Operation.
  - ras_empty reflects occupancy.
- PC_RAS_EN undefined:
  - No RAS storage.
  - call and ret are ignored.
  - jr always uses jump_target.
  - ras_empty is constant 1.

## Test plan

1. Reset then free-run: reset for 2 cycles, then release. pc = 0x0, then 0x4, 0x8, 0xC on successive edges. Set RESET_VECTOR=0x400 and the first pc = 0x400.
2. Priority: branch_taken=1 with branch_target=0x100 and jump=1 with jump_target=0x200 in the same cycle gives pc=0x100. Add exception=1 in that cycle and pc=0x8000_0180.
3. Stall with redirect:
   - stall=1 for 3 cycles from pc=0x20.
   - Cycle 1: jump to 0x300. Cycle 2: branch to 0x500.
   - pc holds 0x20, redirect_pending=1.
   - On release, pc=0x500 and then 0x504.
4. Wrap-around: force pc to 0xFFFF_FFFC via jump_target. Next pc=0x0000_0000.
5. RAS (PC_RAS_EN, RAS_DEPTH=4):
   - Nested calls from 0x10, 0x40, 0x80, 0xC0, 0x100 (5 pushes, one overflow).
   - Five ret jumps with jump_target=0xDEAD.
   - PC sequence: 0x104, 0xC4, 0x84, 0x44, then 0xDEAD, with ras_empty=1 at the end.
6. Reset mid-stall with a pending branch: pc=RESET_VECTOR, redirect_pending=0. After release, no branch is taken.
